// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register and instruction register with a ready/valid output to decode.
// Define MISALIGN_TRAP_EN to trap misaligned fetches in a sticky FAULT state instead of aligning redirect targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        clock,
  input  logic        resetSignal,
  output logic [31:0] programCounter,
  input  logic [31:0] instruction,
  input  logic        fetchEnable,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instrOut,
  output logic [31:0] instrPc,
  output logic [31:0] pcPlus4,
  output logic        fetchFault
);
`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
  logic [31:0] target;
  logic        misaligned;
  assign target     = redirectTarget;
  assign misaligned = |programCounter[1:0];
`else
  typedef enum logic {IDLE, FETCH} state_t;
  logic [31:0] target;
  logic        misaligned;
  assign target     = {redirectTarget[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif
  state_t state;
  logic   capture;
  assign capture = state == FETCH && fetchEnable && (!instrValid || instrReady) && !redirectValid;
  assign pcPlus4 = instrPc + 32'd4;
`ifdef MISALIGN_TRAP_EN
  assign fetchFault = state == FAULT;
`else
  assign fetchFault = 1'b0;
`endif
  always_ff @(posedge clock or negedge resetSignal)
    if (!resetSignal) begin
      state          <= IDLE;
      programCounter <= RESET_VECTOR;
      instrValid     <= 1'b0;
      instrOut       <= 32'd0;
      instrPc        <= 32'd0;
    end else begin
      if (redirectValid) begin
        programCounter <= target;
        instrValid     <= 1'b0;
      end else if (capture && !misaligned) begin
        instrOut       <= instruction;
        instrPc        <= programCounter;
        instrValid     <= 1'b1;
        programCounter <= programCounter + 32'd4;
      end else if (instrReady || capture) begin
        instrValid     <= 1'b0;
      end
      case (state)
        IDLE:    state <= fetchEnable && !redirectValid ? FETCH : IDLE;
`ifdef MISALIGN_TRAP_EN
        FETCH:   state <= capture && misaligned ? FAULT : fetchEnable ? FETCH : IDLE;
        default: state <= redirectValid && redirectTarget[1:0] == 2'b00 ? IDLE : FAULT;
`else
        default: state <= fetchEnable ? FETCH : IDLE;
`endif
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: vector table, corner sequences and a randomized run against a reference model.
module tb_instruction_fetch_unit;
  logic        clock = 1'b0, resetSignal = 1'b0, fetchEnable = 1'b0, redirectValid = 1'b0, instrReady = 1'b0;
  logic [31:0] redirectTarget = 32'd0;
  logic [31:0] programCounter, instruction, instrOut, instrPc, pcPlus4;
  logic        instrValid, fetchFault;
  logic        rst_b = 1'b0, fe_b = 1'b0;
  logic [31:0] pc_b, instr_b, out_b, ipc_b, p4_b;
  logic        valid_b, fault_b;
  int          checks = 0, failures = 0;

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] pc, ipc;
  } vec_t;
  vec_t vt [18];

  always #5 clock = ~clock;
  assign instruction = programCounter ^ 32'hA5A5A5A5;
  assign instr_b     = pc_b ^ 32'hA5A5A5A5;

  instruction_fetch_unit dut (
    .clock(clock), .resetSignal(resetSignal), .programCounter(programCounter), .instruction(instruction),
    .fetchEnable(fetchEnable), .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .instrValid(instrValid), .instrReady(instrReady), .instrOut(instrOut), .instrPc(instrPc),
    .pcPlus4(pcPlus4), .fetchFault(fetchFault)
  );

  instruction_fetch_unit #(.RESET_VECTOR(32'hFFFFFFF8)) dut_b (
    .clock(clock), .resetSignal(rst_b), .programCounter(pc_b), .instruction(instr_b),
    .fetchEnable(fe_b), .redirectValid(1'b0), .redirectTarget(32'd0),
    .instrValid(valid_b), .instrReady(1'b1), .instrOut(out_b), .instrPc(ipc_b),
    .pcPlus4(p4_b), .fetchFault(fault_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
    fetchEnable = fe; instrReady = rdy; redirectValid = rv; redirectTarget = tgt;
  endtask

  task automatic check_out(input string name, input logic valid, input logic [31:0] pc, input logic [31:0] ipc);
    chk({name, ".valid"}, {31'd0, instrValid}, {31'd0, valid});
    chk({name, ".pc"}, programCounter, pc);
    chk({name, ".ipc"}, instrPc, ipc);
    chk({name, ".plus4"}, pcPlus4, ipc + 32'd4);
    chk({name, ".fault"}, {31'd0, fetchFault}, 32'd0);
    if (valid) chk({name, ".data"}, instrOut, ipc ^ 32'hA5A5A5A5);
  endtask

  task automatic check_reset(input string name);
    chk({name, ".pc"}, programCounter, 32'd0);
    chk({name, ".valid"}, {31'd0, instrValid}, 32'd0);
    chk({name, ".out"}, instrOut, 32'd0);
    chk({name, ".ipc"}, instrPc, 32'd0);
    chk({name, ".plus4"}, pcPlus4, 32'd4);
    chk({name, ".fault"}, {31'd0, fetchFault}, 32'd0);
  endtask

  initial begin
    logic        m_run, m_valid, take, fe, rdy, rv;
    logic [31:0] m_pc, m_ipc, m_out, tgt;
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 32'h000};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 32'h000};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 32'h004};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 32'h008};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 32'h008};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 32'h008};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 32'h008};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 32'h00C};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 32'h00C};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h100, 32'h00C};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h100};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h100};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h104, 32'h100};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, 32'h100};
    vt[14] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h200, 32'h100};
    vt[15] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 32'h200};
    vt[16] = '{1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h300, 32'h200};
    vt[17] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 32'h300};

    step; step;
    check_reset("reset");
    resetSignal = 1'b1; rst_b = 1'b1; fe_b = 1'b1;

    // wrap-around with a high reset vector: one idle edge, then captures
    step;
    chk("wrap.start_valid", {31'd0, valid_b}, 32'd0);
    step;
    chk("wrap.ipc0", ipc_b, 32'hFFFFFFF8);
    step;
    chk("wrap.ipc1", ipc_b, 32'hFFFFFFFC);
    chk("wrap.plus4", p4_b, 32'h00000000);
    step;
    chk("wrap.ipc2", ipc_b, 32'h00000000);
    chk("wrap.data", out_b, 32'hA5A5A5A5);
    chk("wrap.fault", {31'd0, fault_b}, 32'd0);
    fe_b = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].fe, vt[i].rdy, vt[i].rv, vt[i].tgt);
      step;
      check_out($sformatf("vec%0d", i), vt[i].valid, vt[i].pc, vt[i].ipc);
    end

    // misaligned redirect
    drive(1'b1, 1'b1, 1'b1, 32'h102);
    step;
`ifdef MISALIGN_TRAP_EN
    chk("mis.pc", programCounter, 32'h102);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step;
    chk("mis.fault", {31'd0, fetchFault}, 32'd1);
    chk("mis.valid", {31'd0, instrValid}, 32'd0);
    step;
    chk("mis.sticky", {31'd0, fetchFault}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    step;
    chk("mis.clear", {31'd0, fetchFault}, 32'd0);
    chk("mis.pc200", programCounter, 32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step;
    chk("mis.idle_valid", {31'd0, instrValid}, 32'd0);
    step;
    check_out("mis.resume", 1'b1, 32'h204, 32'h200);
`else
    chk("mis.pc", programCounter, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step;
    check_out("mis.aligned", 1'b1, 32'h104, 32'h100);
`endif

    // asynchronous reset mid-cycle while holding a valid instruction
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step;
    chk("async.pre_valid", {31'd0, instrValid}, 32'd1);
    #2 resetSignal = 1'b0;
    #1 check_reset("async");
    step;
    resetSignal = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step;
    chk("post.edge1_valid", {31'd0, instrValid}, 32'd0);
    step;
    check_out("post.edge2", 1'b1, 32'h4, 32'h0);

    // randomized run from a clean reset
    resetSignal = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step;
    resetSignal = 1'b1;
    m_run = 1'b0; m_valid = 1'b0; m_pc = 32'd0; m_ipc = 32'd0; m_out = 32'd0;
    for (int i = 0; i < 400; i++) begin
      fe  = $urandom_range(0, 9) != 0;
      rdy = $urandom_range(0, 2) != 0;
      rv  = $urandom_range(0, 11) == 0;
      tgt = $urandom;
`ifdef MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      drive(fe, rdy, rv, tgt);
      take = m_run && fe && (!m_valid || rdy) && !rv;
      if (rv) begin
        m_pc = {tgt[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (take) begin
        m_ipc = m_pc;
        m_out = m_pc ^ 32'hA5A5A5A5;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      m_run = fe && (m_run || !rv);
      step;
      chk("rnd.pc", programCounter, m_pc);
      chk("rnd.valid", {31'd0, instrValid}, {31'd0, m_valid});
      chk("rnd.ipc", instrPc, m_ipc);
      chk("rnd.out", instrOut, m_out);
      chk("rnd.fault", {31'd0, fetchFault}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h00000000, PC value loaded on reset.
REQ-002 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: resetSignal  in  1  asynchronous, active-low reset; asserting it (0) resets immediately and does not wait for a clock edge.
REQ-004 Port: programCounter  out  32  fetch address to InstructionMemoryUnit; registered.
REQ-005 Port: instruction  in  32  word returned combinationally by InstructionMemoryUnit for programCounter.
REQ-006 Port: fetchEnable  in  1  level; 1 = sequential fetching permitted.
REQ-007 Port: redirectValid  in  1  one-cycle request to load redirectTarget (branch/jump).
REQ-008 Port: redirectTarget  in  32  new fetch address.
REQ-009 Port: instrValid  out  1  instrOut/instrPc hold a valid fetched instruction.
REQ-010 Port: instrReady  in  1  downstream decode accepts the instruction this cycle.
REQ-011 Port: instrOut  out  32  registered instruction word (instruction register).
REQ-012 Port: instrPc  out  32  address instrOut was fetched from.
REQ-013 Port: pcPlus4  out  32  instrPc + 4, modulo 2^32.
REQ-014 Port: fetchFault  out  1  sticky misaligned-fetch flag (see Configuration).

Function
REQ-015 FSM states: IDLE, FETCH, FAULT (FAULT exists only with the macro).
REQ-016 Capture condition: capture = (state==FETCH) && fetchEnable && (!instrValid || instrReady) && !redirectValid.
REQ-017 On capture: instrOut<=instruction, instrPc<=programCounter, instrValid<=1, programCounter<=programCounter+4. Latency: the word at address A appears on instrOut one edge after programCounter==A.
REQ-018 Transfer occurs when instrValid && instrReady; if no capture happens in the same cycle, instrValid<=0.
REQ-019 Stall: instrValid && !instrReady; instrOut, instrPc, and programCounter are held unchanged.
REQ-020 Redirect has the highest priority in every state: programCounter<=redirectTarget, instrValid<=0 (flush), and no capture; this applies even during a stall.
REQ-021 IDLE->FETCH on an edge with fetchEnable=1; FETCH->IDLE on an edge with fetchEnable=0. The instruction held in IDLE remains valid until accepted.
REQ-022 A redirect in IDLE updates programCounter, flushes, and stays in IDLE.
REQ-023 PC wrap: 32'hFFFFFFFC + 4 = 32'h00000000; no flag is raised.
REQ-024 Simultaneous transfer and capture in one cycle: back-to-back, instrValid stays 1, so throughput is 1 instruction/cycle.

Reset
REQ-025 While resetSignal=0: programCounter=RESET_VECTOR, instrValid=0, instrOut=0, instrPc=0, pcPlus4=4, fetchFault=0, state=IDLE.
REQ-026 Reset mid-stall or mid-redirect discards all pending state; the first capture after release occurs on the second rising edge with fetchEnable=1 (IDLE->FETCH, then capture).

Configuration
REQ-027 Macro MISALIGN_TRAP_EN.
REQ-028 Defined: if programCounter[1:0]!=0 when capture would occur, go to FAULT instead of capturing; set fetchFault=1 and instrValid<=0.
REQ-029 Defined: FAULT is left only by reset or by a redirect with target[1:0]==0 (->IDLE, fetchFault<=0); a misaligned redirect stays in FAULT.
REQ-030 Not defined: redirectTarget[1:0] is forced to 2'b00 on load, fetchFault is tied to 0, and no FAULT state exists.

Verification
REQ-031 Reset, then fetchEnable=1, instrReady=1, memory word(A)=A^32'hA5A5A5A5 -> instrPc 0,4,8,C on consecutive cycles after a 2-edge startup; pcPlus4 = instrPc+4.
REQ-032 instrReady=0 for 3 cycles with instrPc=32'h8 -> instrOut/instrPc/programCounter frozen (programCounter=32'hC); resumes with instrPc=32'hC the cycle after instrReady=1.
REQ-033 redirectValid=1, target 32'h100, during a stall -> next edge instrValid=0, programCounter=32'h100; following edge instrPc=32'h100.
REQ-034 RESET_VECTOR=32'hFFFFFFF8, free-run -> instrPc FFFFFFF8, FFFFFFFC, 00000000; no fault.
REQ-035 With MISALIGN_TRAP_EN, redirect to 32'h102 -> fetchFault=1, instrValid=0; redirect to 32'h200 -> fetchFault=0, state IDLE. Without the macro, the same stimulus -> instrPc=32'h100, fetchFault=0.
REQ-036 Drive resetSignal=0 asynchronously mid-cycle while instrValid=1 -> outputs take reset values immediately, before the next edge.
